formula_stream: RTL
===================

// Module: formula_stream
// PURPOSE
//  Streaming successor to the fixed-latency formula pipeline.
//  - Computes q = sat_M( ((a - b) * (1 + 3*c) - 4*d) / 2 ).
//  - Adds a valid/ready handshake with backpressure, a per-transaction rounding mode,
//    a configurable output width and a sticky saturation flag.
//  - Sits between a stream source and sink in the datapath; one transaction per clock.
// PARAMETERS
//  N  8  signed input width of a, b, c, d (N >= 2)
//  M  N  signed output width of q (2 <= M <= 2*N+3; elaboration $error otherwise)
// PORTS
//  clk      in   1    clock; all logic on rising edge
//  rstn     in   1    reset, asynchronous, active-low
//  i_valid  in   1    input transaction valid
//  i_ready  out  1    block accepts input this cycle
//  i_round  in   1    0: floor (x>>>1); 1: round half up ((x+1)>>>1); travels with its data
//  a,b,c,d  in   N    signed operands
//  o_valid  out  1    output transaction valid
//  o_ready  in   1    sink accepts output this cycle
//  q        out  M    signed saturated result
//  o_clamp  out  1    the current q was clamped (qualified by o_valid)
//  o_sat    out  1    sticky: some transferred result was clamped since reset or clear
//  i_clr    in   1    synchronous clear of o_sat (and of o_sat_cnt when present)
// BEHAVIOUR
//  - Reset: async assert clears all stage valids, o_valid, o_sat and o_sat_cnt.
//    Data registers are don't-care; the bench checks only valid-qualified data.
//    i_ready is 1 out of reset. A reset mid-stream drops all in-flight transactions.
//  - Pipeline: 5 register stages, fixed latency 5 cycles from input accept to o_valid.
//    The latency holds only when no stall occurs.
//    - S1: a-b (N+1), 3c (N+2), 4d (N+2).
//    - S2: 1+3c (N+2).
//    - S3: product (2N+3).
//    - S4: sign-extended subtraction (2N+4).
//    - S5: optional +1 (i_round), then >>>1 (2N+3).
//    - Saturation is combinational on S5: clamp to [-2^(M-1), 2^(M-1)-1].
//    - All intermediates are sign-extended; no intermediate may wrap for any input.
//  - Handshake:
//    - Global enable en = !o_valid || o_ready.
//    - All stages, including the valid bits, advance only when en = 1. i_ready = en.
//    - Input transfers when i_valid && i_ready. Output transfers when o_valid && o_ready.
//    - Stall: while o_valid && !o_ready, all stages hold. q, o_clamp and o_valid stay stable.
//    - Transactions are never dropped, duplicated or reordered.
//    - Bubbles advance with the pipe; a bubble at the output stage never blocks.
//    - i_ready may depend combinationally on o_ready. No other comb input-to-output path exists.
//  - o_clamp: equals the saturation compare result of the S5 value.
//  - o_sat:
//    - Set on an output transfer with o_clamp = 1.
//    - Cleared by i_clr; i_clr has priority over a simultaneous set.
//    - Updates the cycle after the event.
//  - Rounding: i_round is sampled at input accept and piped alongside the data.
//    Mixed modes in flight are legal.
// CONFIGURATION
//  - FORMULA_SAT_CNT_EN defined:
//    - Adds output o_sat_cnt [15:0].
//    - Counts output transfers with o_clamp = 1 and saturates at 16'hFFFF (no wrap).
//    - i_clr zeroes it, with priority over a simultaneous increment.
//  - Undefined: port o_sat_cnt is absent. No counter logic is built.
// TESTING (N=8, M=8 unless noted)
//  1. Reset: hold rstn=0 -> o_valid=0, o_sat=0, i_ready=1. Release; idle 10 clk -> o_valid stays 0.
//  2. a=3 b=1 c=2 d=1 round=0, o_ready=1 -> q=5 exactly 5 clk after accept, o_clamp=0.
//     Then 20 back-to-back random vectors -> match the golden model, one result per clk.
//  3. Rounding: a=0 b=1 c=0 d=0 (x=-1).
//     - round=0 -> q=-1.
//     - round=1 -> q=0.
//     - Case x=3 (a=3 b=0 c=0 d=0): round=1 -> q=2.
//  4. Saturation:
//     - a=127 b=-128 c=127 d=0 -> q=127, o_clamp=1, o_sat=1 next clk.
//     - a=-128 b=127 c=127 d=0 -> q=-128.
//     - i_clr=1 -> o_sat=0.
//  5. Backpressure: stream 8 vectors, o_ready=0 for cycles 6-9.
//     - i_ready=0 while stalled; q held stable.
//     - All 8 results arrive in order with no loss or duplicates.
//  6. Reset mid-stream: assert rstn=0 with 3 transactions in flight.
//     - o_valid drops to 0 immediately.
//     - No stale result appears after release.
//     - With FORMULA_SAT_CNT_EN: 3 clamped transfers -> o_sat_cnt=3.

Source files
------------

// File: rtl/formula_stream_if.sv
// Stream bundle for formula_stream: input operands with handshake, result with handshake and status.
// The optional o_sat_cnt signal exists only when FORMULA_SAT_CNT_EN is defined.
interface formula_stream_if #(
  parameter int N = 8,
  parameter int M = N
);
  logic                i_valid;
  logic                i_ready;
  logic                i_round;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic signed [N-1:0] c;
  logic signed [N-1:0] d;
  logic                o_valid;
  logic                o_ready;
  logic signed [M-1:0] q;
  logic                o_clamp;
  logic                o_sat;
  logic                i_clr;
`ifdef FORMULA_SAT_CNT_EN
  logic [15:0]         o_sat_cnt;
`endif

  modport slave (
    input  i_valid, i_round, a, b, c, d, o_ready, i_clr,
    output i_ready, o_valid, q, o_clamp, o_sat
`ifdef FORMULA_SAT_CNT_EN
    , output o_sat_cnt
`endif
  );

  modport master (
    output i_valid, i_round, a, b, c, d, o_ready, i_clr,
    input  i_ready, o_valid, q, o_clamp, o_sat
`ifdef FORMULA_SAT_CNT_EN
    , input o_sat_cnt
`endif
  );
endinterface

// File: rtl/formula_stream.sv
// Streaming q = sat_M(((a-b)*(1+3c) - 4d) / 2), 5-stage pipe with global-enable backpressure.
// Optional feature macro: FORMULA_SAT_CNT_EN adds a saturating 16-bit clamp counter (o_sat_cnt).
module formula_stream #(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic           clk,
  input  logic           rstn,
  formula_stream_if.slave bus
);
  localparam int WD = N + 1;
  localparam int W1 = N + 2;
  localparam int WP = 2 * N + 3;
  localparam int WS = 2 * N + 4;
  localparam logic signed [WP-1:0] QMAX = {{(WP-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [WP-1:0] QMIN = ~QMAX;

  generate
    if (N < 2 || M < 2 || M > 2 * N + 3) begin : g_bad_param
      $error("formula_stream: illegal parameters N=%0d M=%0d", N, M);
    end
  endgenerate

  function automatic logic signed [WP-1:0] half_round(input logic signed [WS-1:0] x,
                                                      input logic rnd);
    logic signed [WS:0] t;
    t = (WS+1)'(x) + (WS+1)'(rnd);
    return WP'(t >>> 1);
  endfunction

  function automatic logic clamp_hit(input logic signed [WP-1:0] x);
    return (x > QMAX) || (x < QMIN);
  endfunction

  function automatic logic signed [M-1:0] sat_m(input logic signed [WP-1:0] x);
    if (x > QMAX) return QMAX[M-1:0];
    else if (x < QMIN) return QMIN[M-1:0];
    return x[M-1:0];
  endfunction

  logic en;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q;
  logic rnd_p1_q, rnd_p2_q, rnd_p3_q, rnd_p4_q;
  logic signed [WD-1:0] diff_p1_d, diff_p1_q, diff_p2_q;
  logic signed [W1-1:0] c_x, c3_p1_d, c3_p1_q, c31_p2_d, c31_p2_q;
  logic signed [W1-1:0] d4_p1_d, d4_p1_q, d4_p2_q, d4_p3_q;
  logic signed [WP-1:0] prod_p3_d, prod_p3_q, res_p5_d, res_p5_q;
  logic signed [WS-1:0] sub_p4_d, sub_p4_q;
  logic                 xfer_clamp, sat_d, sat_q;

  // Every stage, valids included, moves only when the output slot is free or draining.
  assign en          = !vld_p5_q || bus.o_ready;
  assign bus.i_ready = en;

  always_comb begin
    c_x       = W1'(bus.c);
    diff_p1_d = WD'(bus.a) - WD'(bus.b);
    c3_p1_d   = c_x + (c_x <<< 1);
    d4_p1_d   = W1'(bus.d) <<< 2;
    c31_p2_d  = c3_p1_q + W1'(1);
    prod_p3_d = WP'(diff_p2_q) * WP'(c31_p2_q);
    sub_p4_d  = WS'(prod_p3_q) - WS'(d4_p3_q);
    res_p5_d  = half_round(sub_p4_q, rnd_p4_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      vld_p5_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= bus.i_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
      vld_p5_q <= vld_p4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // S1: operand pre-scaling
      diff_p1_q <= diff_p1_d;
      c3_p1_q   <= c3_p1_d;
      d4_p1_q   <= d4_p1_d;
      rnd_p1_q  <= bus.i_round;
      // S2: 1 + 3c
      diff_p2_q <= diff_p1_q;
      c31_p2_q  <= c31_p2_d;
      d4_p2_q   <= d4_p1_q;
      rnd_p2_q  <= rnd_p1_q;
      // S3: product
      prod_p3_q <= prod_p3_d;
      d4_p3_q   <= d4_p2_q;
      rnd_p3_q  <= rnd_p2_q;
      // S4: subtract 4d
      sub_p4_q  <= sub_p4_d;
      rnd_p4_q  <= rnd_p3_q;
      // S5: round and halve
      res_p5_q  <= res_p5_d;
    end
  end

  assign bus.o_valid = vld_p5_q;
  assign bus.o_clamp = clamp_hit(res_p5_q);
  assign bus.q       = sat_m(res_p5_q);

  // Clear wins over a clamped transfer in the same cycle.
  assign xfer_clamp = vld_p5_q && bus.o_ready && bus.o_clamp;
  assign sat_d      = bus.i_clr ? 1'b0 : (sat_q || xfer_clamp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign bus.o_sat = sat_q;

`ifdef FORMULA_SAT_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_clr) cnt_d = 16'h0000;
    else if (xfer_clamp && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'h0001;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= 16'h0000;
    else       cnt_q <= cnt_d;
  end

  assign bus.o_sat_cnt = cnt_q;
`endif
endmodule
